// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation core: FSM state encoding
// and the default operand width.
package modexp_pkg;
  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SQUARE = 3'd2,
    MULT   = 3'd3,
    FINISH = 3'd4
  } state_t;
endpackage

// File: rtl/modexp_if.sv
// Request/response bundle of the modular exponentiation core.
interface modexp_if #(parameter int WIDTH = modexp_pkg::DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exp;
  logic [WIDTH-1:0] mod;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (output start, base, exp, mod, input busy, done, result, err);
  modport slave  (input start, base, exp, mod, output busy, done, result, err);
endinterface

// File: rtl/modexp_core_modmul.sv
// Bit-serial interleaved shift-add modular multiplier: p = a*b mod m in
// exactly WIDTH+1 cycles (one load cycle, WIDTH bit steps). Requires a,b < m.
module modmul
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [RW-1:0]    a_reg, m_reg, r_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg, done_reg;
  logic [RW-1:0]    r_dbl, r_s1, r_step;

  // 2r + a stays below 3m, so two conditional subtractions fully reduce it.
  always_comb begin
    r_dbl  = (r_reg << 1) + (b_reg[WIDTH-1] ? a_reg : '0);
    r_s1   = (r_dbl >= m_reg) ? (r_dbl - m_reg) : r_dbl;
    r_step = (r_s1 >= m_reg) ? (r_s1 - m_reg) : r_s1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      m_reg    <= '0;
      r_reg    <= '0;
      b_reg    <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        a_reg   <= RW'(a);
        m_reg   <= RW'(m);
        b_reg   <= b;
        r_reg   <= '0;
        cnt_reg <= CW'(WIDTH);
        run_reg <= 1'b1;
      end else if (run_reg) begin
        r_reg   <= r_step;
        b_reg   <= b_reg << 1;
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign p    = r_reg[WIDTH-1:0];
endmodule

// File: rtl/modexp_core.sv
// Left-to-right square-and-multiply modular exponentiation (result = base^exp mod mod).
// Defining MODEXP_LZ_SKIP_EN starts from the top set bit of exp, skipping leading-zero squarings.
module modexp_core
  import modexp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  modexp_if.slave   bus
);
  localparam int IW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] base_reg, exp_reg, mod_reg;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             fault_reg, fault_next;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg, done_reg;
  logic             mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;

`ifdef MODEXP_LZ_SKIP_EN
  logic [IW-1:0] msb_idx;
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (exp_reg[i]) msb_idx = IW'(i);
  end
`endif

  modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk(clk), .rst(rst), .start(mm_start),
    .a(mm_a), .b(mm_b), .m(mod_reg), .done(mm_done), .p(mm_p)
  );

  // Each multiply is launched on the same edge that retires the previous one,
  // so operands come straight from the multiplier output when chaining.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    fault_next = fault_reg;
    mm_start   = 1'b0;
    mm_a       = acc_reg;
    mm_b       = acc_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        if (mod_reg == '0 || base_reg >= mod_reg) begin
          acc_next = '0; fault_next = 1'b1; state_next = FINISH;
        end else if (mod_reg == WIDTH'(1)) begin
          acc_next = '0; state_next = FINISH;
        end else if (exp_reg == '0) begin
          acc_next = WIDTH'(1); state_next = FINISH;
        end else begin
`ifdef MODEXP_LZ_SKIP_EN
          acc_next = base_reg;
          if (msb_idx == '0) begin
            state_next = FINISH;
          end else begin
            idx_next = msb_idx - IW'(1);
            mm_start = 1'b1; mm_a = base_reg; mm_b = base_reg;
            state_next = SQUARE;
          end
`else
          acc_next = WIDTH'(1);
          idx_next = IW'(WIDTH - 1);
          mm_start = 1'b1; mm_a = WIDTH'(1); mm_b = WIDTH'(1);
          state_next = SQUARE;
`endif
        end
      end
      SQUARE: if (mm_done) begin
        acc_next = mm_p;
        if (exp_reg[idx_reg]) begin
          mm_start = 1'b1; mm_a = mm_p; mm_b = base_reg;
          state_next = MULT;
        end else if (idx_reg == '0) begin
          state_next = FINISH;
        end else begin
          idx_next = idx_reg - IW'(1);
          mm_start = 1'b1; mm_a = mm_p; mm_b = mm_p;
        end
      end
      MULT: if (mm_done) begin
        acc_next = mm_p;
        if (idx_reg == '0) begin
          state_next = FINISH;
        end else begin
          idx_next = idx_reg - IW'(1);
          mm_start = 1'b1; mm_a = mm_p; mm_b = mm_p;
          state_next = SQUARE;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      exp_reg    <= '0;
      mod_reg    <= '0;
      acc_reg    <= '0;
      idx_reg    <= '0;
      fault_reg  <= 1'b0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      fault_reg <= fault_next;
      done_reg  <= (state_reg == FINISH);
      if (state_reg == IDLE && bus.start) begin
        base_reg  <= bus.base;
        exp_reg   <= bus.exp;
        mod_reg   <= bus.mod;
        fault_reg <= 1'b0;
        err_reg   <= 1'b0;
      end
      if (state_reg == FINISH) begin
        result_reg <= acc_reg;
        err_reg    <= fault_reg;
      end
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.err    = err_reg;
endmodule

// File: tb/tb_modexp_core.sv
// Directed bench for modexp_core at WIDTH=8 and WIDTH=16; expected latencies follow MODEXP_LZ_SKIP_EN.
module tb_modexp_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  modexp_if #(.WIDTH(8))  bus8();
  modexp_if #(.WIDTH(16)) bus16();

  modexp_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  modexp_core #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

`ifdef MODEXP_LZ_SKIP_EN
  localparam int LAT_7_3   = 20;
  localparam int LAT_5_1   = 2;
  localparam int LAT_0_5   = 29;
  localparam int LAT_200   = 128;
  localparam int LAT_4_13  = 87;
`else
  localparam int LAT_7_3   = 92;
  localparam int LAT_5_1   = 83;
  localparam int LAT_0_5   = 92;
  localparam int LAT_200   = 146;
  localparam int LAT_4_13  = 325;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, want);
    end
  endtask

  // Call at posedge+1; start is sampled on the following edge.
  task automatic run_op(input int w, input logic [15:0] b, input logic [15:0] e,
                        input logic [15:0] m, input logic [15:0] want_res,
                        input logic want_err, input int want_lat, input bit poke,
                        input string tag);
    int cnt;
    logic seen;
    logic [15:0] res;
    logic er;
    if (w == 8) begin
      bus8.start = 1'b1; bus8.base = b[7:0]; bus8.exp = e[7:0]; bus8.mod = m[7:0];
    end else begin
      bus16.start = 1'b1; bus16.base = b; bus16.exp = e; bus16.mod = m;
    end
    @(posedge clk); #1;
    bus8.start = 1'b0; bus16.start = 1'b0;
    check({tag, "_busy"}, (w == 8) ? bus8.busy : bus16.busy, 1);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 4000) begin
      @(posedge clk); #1;
      cnt++;
      if (poke && cnt == 10) begin
        bus16.start = 1'b1; bus16.base = 16'd1; bus16.exp = 16'd1; bus16.mod = 16'd3;
      end
      if (cnt == 11) bus16.start = 1'b0;
      seen = (w == 8) ? bus8.done : bus16.done;
    end
    bus16.start = 1'b0;
    res = (w == 8) ? {8'd0, bus8.result} : bus16.result;
    er  = (w == 8) ? bus8.err : bus16.err;
    check({tag, "_done"}, seen, 1);
    check({tag, "_lat"}, cnt, want_lat);
    check({tag, "_res"}, res, want_res);
    check({tag, "_err"}, er, want_err);
    $display("txn %s w=%0d base=%0d exp=%0d mod=%0d result=%0d err=%0d cycles=%0d",
             tag, w, b, e, m, res, er, cnt);
  endtask

  initial begin
    bus8.start = 1'b0;  bus8.base = '0;  bus8.exp = '0;  bus8.mod = '0;
    bus16.start = 1'b0; bus16.base = '0; bus16.exp = '0; bus16.mod = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy",   bus8.busy, 0);
    check("rst_done",   bus8.done, 0);
    check("rst_err",    bus8.err, 0);
    check("rst_result", bus8.result, 0);

    run_op(8, 16'd7,   16'd3,   16'd11,  16'd2,   1'b0, LAT_7_3,  1'b0, "w8_7_3_11");
    run_op(8, 16'd5,   16'd1,   16'd11,  16'd5,   1'b0, LAT_5_1,  1'b0, "w8_exp1");
    run_op(8, 16'd0,   16'd5,   16'd11,  16'd0,   1'b0, LAT_0_5,  1'b0, "w8_base0");
    run_op(8, 16'd200, 16'd255, 16'd251, 16'd102, 1'b0, LAT_200,  1'b0, "w8_big");
    run_op(8, 16'd9,   16'd4,   16'd0,   16'd0,   1'b1, 2,        1'b0, "w8_mod0");
    run_op(8, 16'd12,  16'd3,   16'd11,  16'd0,   1'b1, 2,        1'b0, "w8_base_ge");
    run_op(8, 16'd0,   16'd9,   16'd1,   16'd0,   1'b0, 2,        1'b0, "w8_mod1");
    run_op(8, 16'd7,   16'd3,   16'd11,  16'd2,   1'b0, LAT_7_3,  1'b0, "w8_after_err");

    run_op(16, 16'd4,   16'd13, 16'd497, 16'd445, 1'b0, LAT_4_13, 1'b0, "w16_4_13");
    run_op(16, 16'd445, 16'd0,  16'd497, 16'd1,   1'b0, 2,        1'b0, "w16_exp0");
    run_op(16, 16'd4,   16'd13, 16'd497, 16'd445, 1'b0, LAT_4_13, 1'b1, "w16_poke");
    run_op(16, 16'd445, 16'd0,  16'd497, 16'd1,   1'b0, 2,        1'b0, "w16_exp0b");

    // Abort an operation while the first squaring is in progress.
    bus8.start = 1'b1; bus8.base = 8'd7; bus8.exp = 8'd3; bus8.mod = 8'd11;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", bus8.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",   bus8.busy, 0);
    check("mid_rst_done",   bus8.done, 0);
    check("mid_rst_err",    bus8.err, 0);
    check("mid_rst_result", bus8.result, 0);
    check("mid_rst_r16",    bus16.result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8, 16'd7, 16'd3, 16'd11, 16'd2, 1'b0, LAT_7_3, 1'b0, "w8_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
